// File: rtl/wvb_rdout_writer.sv
// wvb_rdout_writer
//   Pops whole waveforms (header + samples) from the waveform buffer and packs
//   them into the 1024 x 32 direct-readout DPRAM.
//   Each completed transfer is announced to xdom with a one-cycle run strobe
//   and a length.
//   The block then waits for xdom's busy/done handshake before it refills.
//   dpram_mode 0 sends one waveform per transfer; mode 1 packs as many whole
//   waveforms as fit.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   enable                reader enable from xdom
//   dpram_mode            0 = one waveform per transfer, 1 = pack multiple
//   dpram_busy            xdom busy (rises after run, falls on xdom done)
//   hdr_empty/ltc/nsamp   show-ahead header FIFO head; hdr_rdreq pops it
//   data_rdreq, data_in   sample FIFO read; data_in valid one cycle later
//   rdout_dpram_*         DPRAM write port, run strobe
//   dpram_len_out         transfer length in 16-bit words, valid with run
//   writer_busy           high whenever the FSM is not idle
//   trunc_cnt             saturating count of truncated waveforms
//
// State table
//   IDLE    | pointer cleared, waiting for enable, header, xdom not busy
//   HDR     | writes header words 0..2, pops header on word 0
//   DATA    | streams sample pairs into the DPRAM (plus odd-sample pad)
//   DRAIN   | reads and discards samples past the truncation point
//   NEXT    | decides between packing another waveform and finishing
//   FIN     | one-cycle run strobe with transfer length
//   WAIT_HI | waiting for xdom busy to rise
//   WAIT_LO | waiting for xdom busy to fall
module wvb_rdout_writer #(
  parameter int          ADDR_W      = 10,
  parameter int          DPRAM_WORDS = 1024,
  parameter logic [14:0] HDR_MARKER  = 15'h2AAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dpram_mode,
  input  logic              dpram_busy,
  input  logic              hdr_empty,
  input  logic [47:0]       hdr_ltc,
  input  logic [11:0]       hdr_nsamp,
  output logic              hdr_rdreq,
  output logic              data_rdreq,
  input  logic [15:0]       data_in,
  output logic              rdout_dpram_wren,
  output logic [ADDR_W-1:0] rdout_dpram_wr_addr,
  output logic [31:0]       rdout_dpram_data,
  output logic              rdout_dpram_run,
  output logic [15:0]       dpram_len_out,
  output logic              writer_busy,
  output logic [15:0]       trunc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_DRAIN, S_NEXT, S_FIN, S_WAIT_HI, S_WAIT_LO
  } state_t;

  localparam logic [12:0]   MAX0     = 13'(2 * (DPRAM_WORDS - 3));
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DPRAM_WORDS);

  state_t            state, state_nxt;
  logic [1:0]        hdr_idx;
  logic [ADDR_W:0]   ptr;
  logic [47:0]       ltc_r;
  logic [11:0]       nsw_r;
  logic [11:0]       rd_left;
  logic [11:0]       rd_idx;
  logic [11:0]       rx_cnt;
  logic [15:0]       hi_r;
  logic              vld_d;
  logic              pad_pend;

  logic [12:0]       max_samp;
  logic              trunc_c;
  logic [11:0]       nsw_c;
  logic [12:0]       w_next;
  logic [12:0]       room;
  logic              we_c;
  logic [31:0]       wd_c;

  // Only meaningful while popping a header; max_samp wraps for pointers past
  // 1021, which never reach HDR because the fit check in NEXT excludes them.
  assign max_samp = MAX0 - 13'({ptr, 1'b0});
  assign trunc_c  = {1'b0, hdr_nsamp} > max_samp;
  assign nsw_c    = trunc_c ? max_samp[11:0] : hdr_nsamp;
  assign w_next   = 13'd3 + ((13'(hdr_nsamp) + 13'd1) >> 1);
  assign room     = 13'(DPRAM_WORDS) - 13'(ptr);

  assign writer_busy = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    hdr_rdreq  = 1'b0;
    data_rdreq = 1'b0;
    we_c       = 1'b0;
    wd_c       = 32'h0;
    case (state)
      S_IDLE: begin
        if (enable && !dpram_busy && !hdr_empty) state_nxt = S_HDR;
      end
      S_HDR: begin
        we_c = 1'b1;
        case (hdr_idx)
          2'd0: begin
            wd_c      = {HDR_MARKER, trunc_c, 4'h0, nsw_c};
            hdr_rdreq = 1'b1;
          end
          2'd1: wd_c = ltc_r[47:16];
          default: begin
            wd_c       = {ltc_r[15:0], 16'h0};
            data_rdreq = (rd_left != 12'd0);
            state_nxt  = S_DATA;
          end
        endcase
      end
      S_DATA: begin
        // Reads run contiguously into the drain samples; only the first
        // nsamp_written of them are marked valid for writing.
        data_rdreq = (rd_left != 12'd0);
        if (vld_d && rx_cnt[0]) begin
          we_c = 1'b1;
          wd_c = {hi_r, data_in};
        end else if (pad_pend) begin
          we_c = 1'b1;
          wd_c = {hi_r, 16'h0};
        end
        if (rx_cnt == nsw_r && !pad_pend) begin
          if ((rd_left - {11'd0, data_rdreq}) != 12'd0) state_nxt = S_DRAIN;
          else                                           state_nxt = S_NEXT;
        end
      end
      S_DRAIN: begin
        data_rdreq = (rd_left != 12'd0);
        if (rd_left <= 12'd1) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (!dpram_mode || !enable || hdr_empty || ptr == PTR_FULL)
          state_nxt = S_FIN;
        else if (w_next <= room)
          state_nxt = S_HDR;
        else
          state_nxt = S_FIN;
      end
      S_FIN:     state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (dpram_busy)  state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!dpram_busy) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      hdr_idx             <= 2'd0;
      ptr                 <= '0;
      ltc_r               <= 48'h0;
      nsw_r               <= 12'd0;
      rd_left             <= 12'd0;
      rd_idx              <= 12'd0;
      rx_cnt              <= 12'd0;
      hi_r                <= 16'h0;
      vld_d               <= 1'b0;
      pad_pend            <= 1'b0;
      rdout_dpram_wren    <= 1'b0;
      rdout_dpram_wr_addr <= '0;
      rdout_dpram_data    <= 32'h0;
      rdout_dpram_run     <= 1'b0;
      dpram_len_out       <= 16'h0;
      trunc_cnt           <= 16'h0;
    end else begin
      state            <= state_nxt;
      hdr_idx          <= (state == S_HDR) ? hdr_idx + 2'd1 : 2'd0;
      rdout_dpram_wren <= we_c;
      if (we_c) begin
        rdout_dpram_wr_addr <= ptr[ADDR_W-1:0];
        rdout_dpram_data    <= wd_c;
        ptr                 <= ptr + 1'b1;
      end
      if (state == S_IDLE) ptr <= '0;

      if (hdr_rdreq) begin
        ltc_r    <= hdr_ltc;
        nsw_r    <= nsw_c;
        rd_left  <= hdr_nsamp;
        rd_idx   <= 12'd0;
        rx_cnt   <= 12'd0;
        if (trunc_c && trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
      end
      if (data_rdreq) begin
        rd_left <= rd_left - 12'd1;
        rd_idx  <= rd_idx + 12'd1;
      end
      vld_d <= data_rdreq && (rd_idx < nsw_r);

      if (pad_pend) pad_pend <= 1'b0;
      if (vld_d) begin
        rx_cnt <= rx_cnt + 12'd1;
        if (!rx_cnt[0]) begin
          hi_r <= data_in;
          // Last sample landing in the high half needs a zero-padded write.
          if (rx_cnt == nsw_r - 12'd1) pad_pend <= 1'b1;
        end
      end

      rdout_dpram_run <= (state == S_FIN);
      if (state == S_FIN) dpram_len_out <= 16'({ptr, 1'b0});
    end
  end

endmodule

// File: doc/wvb_rdout_writer.md
Name: wvb_rdout_writer

Overview:
- Upstream feeder of the xdom direct-readout DPRAM.
- Pops whole waveforms (header plus samples) from the waveform buffer and packs them into the 1024 x 32 direct readout DPRAM.
- Announces each completed transfer to xdom with a one-cycle run strobe and length, then waits for xdom's busy/done handshake before refilling.
- Mode 0 transfers one waveform per transfer; mode 1 packs as many whole waveforms as fit.

Parameters:
- ADDR_W, 10, DPRAM word-address width.
- DPRAM_WORDS, 1024, DPRAM depth in 32-bit words.
- HDR_MARKER, 15'h2AAA, marker placed in header word0 [31:17].

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- enable  in  1  wvb_reader_enable from xdom
- dpram_mode  in  1  0 = one waveform per transfer, 1 = pack multiple
- dpram_busy  in  1  xdom busy: rises the cycle after run, falls on xdom done
- hdr_empty  in  1  header FIFO empty (show-ahead FIFO)
- hdr_ltc  in  48  head-of-FIFO launch time counter
- hdr_nsamp  in  12  head-of-FIFO sample count (0 illegal, never produced)
- hdr_rdreq  out  1  pop header
- data_rdreq  out  1  sample FIFO read; data valid 1 cycle later
- data_in  in  16  sample
- rdout_dpram_wren  out  1  DPRAM write enable
- rdout_dpram_wr_addr  out  ADDR_W  DPRAM write address
- rdout_dpram_data  out  32  DPRAM write data
- rdout_dpram_run  out  1  one-cycle transfer-complete strobe
- dpram_len_out  out  16  transfer length in 16-bit words; valid with run
- writer_busy  out  1  high whenever state is not IDLE
- trunc_cnt  out  16  truncated-waveform counter, saturating

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-transfer abandons the transfer; partially read FIFO contents are not recovered (the bench resets the wvb too).
- Samples for a header are guaranteed present once that header is visible. The block never checks sample-FIFO empty.
- Waveform format, sequential addresses from a running word pointer:
  - word0 = {HDR_MARKER, trunc, 4'h0, nsamp_written}
  - word1 = ltc[47:16]
  - word2 = {ltc[15:0], 16'h0}
  - then pairs {s[2k], s[2k+1]}; an odd final sample is written as {s, 16'h0}.
  - Words per waveform W = 3 + ceil(n/2).
- Truncation: max samples at pointer p = 2*(DPRAM_WORDS-3-p).
  - If n exceeds this, nsamp_written = max and trunc = 1.
  - All n samples are still read; the excess is discarded in DRAIN.
  - trunc_cnt increments by one per truncated waveform.
- States:
  - IDLE: go to HDR when enable & !dpram_busy & !hdr_empty. Pointer = 0.
  - HDR: write word0, word1, word2 on 3 consecutive cycles. hdr_rdreq pulses with the word0 write (fields latched first). data_rdreq starts in the word2 cycle.
  - DATA: data_rdreq high for exactly nsamp_written cycles total, contiguous. One DPRAM write per sample pair; pad write on the cycle after the last odd sample arrives.
  - DRAIN: n - nsamp_written further rdreq cycles, no writes.
  - NEXT:
    - mode 0 or !enable or hdr_empty or pointer = DPRAM_WORDS → FIN.
    - mode 1: if the next header's W ≤ DPRAM_WORDS - pointer → HDR.
    - Otherwise → FIN; the header is not popped.
    - Only the first waveform of a transfer may truncate.
  - FIN: pulse rdout_dpram_run for 1 cycle, dpram_len_out = 2*pointer (1024 words → 2048).
  - WAIT_HI: wait for dpram_busy = 1.
  - WAIT_LO: wait for dpram_busy = 0 → IDLE. No DPRAM writes occur between FIN and IDLE.
- Enable deassert mid-transfer: current waveform completes, transfer is finalized in FIN, handshake completes, then the block stays in IDLE.
- Throughput: 1 sample per clk. Mode-0 latency from IDLE exit to run = 3 + n + 2 cycles (±1 for pad); the bench checks the ordering, not exact counts beyond ±1.

Test Plan:
- Mode 0, n=4, ltc=48'h123456789ABC, samples 1..4 → 5 writes at addr 0..4: 0x55540004, 0x12345678, 0x9ABC0000, 0x00010002, 0x00030004; run pulse with len=10.
- Mode 0, n=3, samples 7,8,9 → word3=0x00070008, word4=0x00090000, len=10.
- Mode 1, three n=8 headers queued → headers at addr 0,7,14; single run with len=42; all 3 headers popped.
- Mode 1, n=2000 then n=100 → first transfer len=2006 and only one header popped; after the busy handshake, second transfer starts at addr 0 with len=106.
- Mode 0, n=2100 → word0=0x555507FA, 1024 writes, len=2048, 2100 data_rdreq pulses, trunc_cnt=1.
- Handshake/reset: hold dpram_busy high 50 cycles after run with 2 headers queued → no writes and no second run until busy falls. Assert rst mid-DATA → all outputs 0 on the next cycle and state IDLE.
